serial_adder: RTL and testbench

Bit-serial ripple adder: accepts two WIDTH-bit operands plus carry-in and computes their sum LSB-first, one bit per clock. Each bit goes through a single full-adder cell built from two half adders (sum = a^b^c, carry = ab | c(a^b)). It is the addition counterpart of the combinational full subtractor in this library. It trades latency for area and sits between a register-file style operand source and any consumer that waits on a done pulse.

---
 rtl/serial_adder.sv | 85 ++++++++
 tb/tb_serial_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell walks the operands LSB-first, one bit per clock,
// and publishes sum/cout/overflow together with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, r, r_nx;
    logic [CW-1:0]    cnt;
    logic             c, s, c_nx, last, accept;

    always_comb begin
        accept = start && (state != RUN);
        last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
        s      = sa[0] ^ sb[0] ^ c;
        c_nx   = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
        // New bit enters at the MSB; written this way so WIDTH=1 needs no special case
        r_nx            = r >> 1;
        r_nx[WIDTH-1]   = s;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa       <= '0;
            sb       <= '0;
            r        <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            c   <= cin;
            cnt <= '0;
            r   <= '0;
        end else if (state == RUN) begin
            r   <= r_nx;
            c   <= c_nx;
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            cnt <= cnt + 1'b1;
            // On the MSB step c is the carry into the MSB, c_nx the carry out of it
            if (last) begin
                sum      <= r_nx;
                cout     <= c_nx;
                overflow <= c ^ c_nx;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main function and corner
// sequences, and a 1-bit instance for the single-step case.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout, overflow;
    logic [7:0] sum;

    logic       start1;
    logic [0:0] a1, b1, sum1;
    logic       cin1, busy1, done1, cout1, ovf1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    typedef struct {
        logic [7:0] a, b;
        logic       cin;
        logic [7:0] s;
        logic       co, ov;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accept one operation, count busy cycles, then check the published result.
    task automatic run_op(input vec_t v, input string tag);
        int n;
        a = v.a; b = v.b; cin = v.cin; start = 1'b1;
        step();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        chk({tag, " latency"}, n, 8);
        chk({tag, " done"}, done, 1);
        chk({tag, " sum"}, sum, v.s);
        chk({tag, " cout"}, cout, v.co);
        chk({tag, " ovf"}, overflow, v.ov);
        step();
        chk({tag, " done 1 cycle"}, done, 0);
    endtask

    task automatic run_op1(input logic ta, input logic tb_, input logic tc,
                           input logic es, input logic ec, input logic eo, input string tag);
        a1 = ta; b1 = tb_; cin1 = tc; start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk({tag, " busy"}, busy1, 1);
        step();
        chk({tag, " done"}, done1, 1);
        chk({tag, " busy off"}, busy1, 0);
        chk({tag, " sum"}, sum1, es);
        chk({tag, " cout"}, cout1, ec);
        chk({tag, " ovf"}, ovf1, eo);
        step();
        chk({tag, " done 1 cycle"}, done1, 0);
    endtask

    initial begin
        vec_t vt[8];
        vec_t bb[4];
        vec_t v;
        logic [8:0] full;
        int n, dcnt, last_done, period;

        vt[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vt[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
        vt[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vt[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[6] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

        bb[0] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
        bb[1] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
        bb[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        bb[3] = '{8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        step(); step();
        // Reset has priority over a pending start
        start = 1'b1;
        step();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sum", sum, 0);
        chk("reset cout", cout, 0);
        chk("reset ovf", overflow, 0);
        chk("reset busy1", busy1, 0);
        start = 1'b0;
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_op(vt[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 1000; i++) begin
            v.a = 8'($urandom); v.b = 8'($urandom); v.cin = 1'($urandom);
            full = {1'b0, v.a} + {1'b0, v.b} + {8'b0, v.cin};
            v.s = full[7:0]; v.co = full[8];
            v.ov = (v.a[7] == v.b[7]) && (full[7] != v.a[7]);
            run_op(v, "rand");
        end

        // start during RUN is ignored: no reload, same busy length, no extra done
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            if (n == 2) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        chk("ignore latency", n, 8);
        chk("ignore done", done, 1);
        chk("ignore sum", sum, 8'h46);
        chk("ignore cout", cout, 0);
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done || busy) dcnt++;
        end
        chk("ignore no extra", dcnt, 0);

        // reset mid-RUN aborts; previous nonzero sum must clear
        run_op(vt[4], "pre-abort");
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort sum", sum, 0);
        chk("abort cout", cout, 0);
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done) dcnt++;
        end
        chk("abort no done", dcnt, 0);
        run_op(vt[3], "post-abort");

        // start held high: next operands are accepted in the DONE cycle,
        // so done repeats with 8 cycles between pulses (period 9)
        a = bb[0].a; b = bb[0].b; cin = bb[0].cin; start = 1'b1;
        step();
        last_done = -1;
        period = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                a = bb[i+1].a; b = bb[i+1].b; cin = bb[i+1].cin;
            end
            n = 0;
            while (!done && n < 40) begin
                step();
                n++;
                period++;
            end
            chk($sformatf("b2b%0d latency", i), n, 8);
            chk($sformatf("b2b%0d sum", i), sum, bb[i].s);
            chk($sformatf("b2b%0d cout", i), cout, bb[i].co);
            chk($sformatf("b2b%0d ovf", i), overflow, bb[i].ov);
            chk($sformatf("b2b%0d busy", i), busy, 0);
            if (last_done >= 0) chk($sformatf("b2b%0d period", i), period - last_done, 9);
            last_done = period;
            if (i == 3) start = 1'b0;
            step();
            period++;
            chk($sformatf("b2b%0d done low", i), done, 0);
        end
        step();
        chk("b2b idle", busy, 0);

        // 1-bit instance: single RUN cycle, overflow = cin ^ cout
        run_op1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "w1 111");
        run_op1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "w1 100");
        run_op1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "w1 001");
        run_op1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "w1 101");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
